// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl : per-stage stall/flush generation, divider handshake with
// watchdog, load-use detection, deferred exceptions. Option macro: HAZ_PERF_EN
// Revision: 1.0
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int          NSTAGE      = 5,
  parameter int          REGW        = 5,
  parameter int          LOAD_LAT    = 1,
  parameter int          ID_STG      = 1,
  parameter int          EX_STG      = 2,
  parameter int          MEM_STG     = 3,
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
  parameter logic [31:0] ERET_CODE   = 32'h0000000E,
  parameter int          DIV_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REGW-1:0]   id_rs,
  input  logic [REGW-1:0]   id_rt,
  input  logic [REGW-1:0]   ex_rt,
  input  logic [REGW-1:0]   mem_rt,
  input  logic              ex_rmem,
  input  logic              mem_rmem,
  input  logic              ex_is_div,
  input  logic              div_ready,
  input  logic              mult_stall,
  input  logic              stallreq_from_if,
  input  logic              stallreq_from_mem,
  input  logic [31:0]       mem_excepttype,
  input  logic [31:0]       mem_cp0_epc,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] flush,
  output logic              div_start,
  output logic              div_cancel,
  output logic              div_timeout,
  output logic [31:0]       newpc,
  output logic              newpc_valid,
  output logic              exc_pending,
  output logic [31:0]       perf_lu,
  output logic [31:0]       perf_div,
  output logic [31:0]       perf_mem
);

  localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DIV_TIMEOUT - 1);
  localparam logic C_LU_MEM = (LOAD_LAT == 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [31:0]      pend_code_q, pend_code_d;
  logic [31:0]      pend_epc_q, pend_epc_d;

  logic w_lu_ex, w_lu_mem, w_lu;
  logic w_div_busy, w_start, w_cancel, w_timeout;
  logic w_exc_flush, w_any;
  logic [31:0] w_code, w_epc;
  logic [NSTAGE-1:0] w_stall_vec, w_flush_vec;
  int w_k;

  assign w_lu_ex  = ex_rmem && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign w_lu_mem = mem_rmem && (mem_rt != '0) && ((mem_rt == id_rs) || (mem_rt == id_rt));
  assign w_lu     = w_lu_ex || (w_lu_mem && C_LU_MEM);

  // A held exception redirects only once memory releases the pipeline.
  assign w_exc_flush = (pend_q || (mem_excepttype != '0)) && !stallreq_from_mem;
  assign w_code      = pend_q ? pend_code_q : mem_excepttype;
  assign w_epc       = pend_q ? pend_epc_q  : mem_cp0_epc;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_start    = 1'b0;
    w_cancel   = 1'b0;
    w_timeout  = 1'b0;
    w_div_busy = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (ex_is_div && !w_exc_flush) begin
          w_start    = 1'b1;
          w_div_busy = 1'b1;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_exc_flush) begin
          w_cancel = 1'b1;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end else begin
          w_div_busy = 1'b1;
          if (div_ready) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else if (cnt_q == C_CNT_MAX) begin
            w_timeout = 1'b1;
            cnt_d     = '0;
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    pend_d      = pend_q;
    pend_code_d = pend_code_q;
    pend_epc_d  = pend_epc_q;
    if (pend_q) begin
      if (!stallreq_from_mem) pend_d = 1'b0;
    end else if ((mem_excepttype != '0) && stallreq_from_mem) begin
      pend_d      = 1'b1;
      pend_code_d = mem_excepttype;
      pend_epc_d  = mem_cp0_epc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_code_q <= '0;
      pend_epc_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_code_q <= pend_code_d;
      pend_epc_q  <= pend_epc_d;
    end
  end

  // Highest stalling stage K: everything at or before K holds, K+1 gets a bubble.
  always_comb begin
    w_any = 1'b1;
    w_k   = 0;
    if (stallreq_from_mem)             w_k = MEM_STG;
    else if (w_div_busy || mult_stall) w_k = EX_STG;
    else if (w_lu)                     w_k = ID_STG;
    else if (stallreq_from_if)         w_k = 0;
    else                               w_any = 1'b0;
    for (int i = 0; i < NSTAGE; i++) begin
      w_stall_vec[i] = w_any && (i <= w_k);
      w_flush_vec[i] = w_any && (i == w_k + 1);
    end
  end

  always_comb begin
    stall       = w_stall_vec;
    flush       = w_flush_vec;
    newpc       = '0;
    newpc_valid = 1'b0;
    if (w_exc_flush) begin
      stall       = '0;
      flush       = '1;
      newpc_valid = 1'b1;
      newpc       = (w_code == ERET_CODE) ? w_epc : EXC_VECTOR;
    end
    if (rst) begin
      stall       = '0;
      flush       = '0;
      newpc       = '0;
      newpc_valid = 1'b0;
    end
  end

  assign div_start   = w_start   && !rst;
  assign div_cancel  = w_cancel  && !rst;
  assign div_timeout = w_timeout && !rst;
  assign exc_pending = pend_q;

`ifdef HAZ_PERF_EN
  logic [31:0] perf_lu_q, perf_div_q, perf_mem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu_q  <= '0;
      perf_div_q <= '0;
      perf_mem_q <= '0;
    end else begin
      if (w_any && (w_k == ID_STG))  perf_lu_q  <= perf_lu_q  + 32'd1;
      if (w_any && (w_k == EX_STG))  perf_div_q <= perf_div_q + 32'd1;
      if (w_any && (w_k == MEM_STG)) perf_mem_q <= perf_mem_q + 32'd1;
    end
  end

  assign perf_lu  = perf_lu_q;
  assign perf_div = perf_div_q;
  assign perf_mem = perf_mem_q;
`else
  assign perf_lu  = '0;
  assign perf_div = '0;
  assign perf_mem = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipe_hazard_ctrl : directed checks on two configurations of the controller
// (LOAD_LAT=1/DIV_TIMEOUT=64 and LOAD_LAT=2/DIV_TIMEOUT=8).
// Revision: 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic        clk, rst;
  logic [4:0]  id_rs, id_rt, ex_rt, mem_rt;
  logic        ex_rmem, mem_rmem, ex_is_div, div_ready, mult_stall;
  logic        stallreq_from_if, stallreq_from_mem;
  logic [31:0] mem_excepttype, mem_cp0_epc;

  logic [4:0]  stall1, flush1, stall2, flush2;
  logic        start1, cancel1, tmo1, nv1, pend1;
  logic        start2, cancel2, tmo2, nv2, pend2;
  logic [31:0] newpc1, newpc2;
  logic [31:0] plu1, pdiv1, pmem1, plu2, pdiv2, pmem2;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl u_dut1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt), .mem_rt(mem_rt),
    .ex_rmem(ex_rmem), .mem_rmem(mem_rmem), .ex_is_div(ex_is_div), .div_ready(div_ready),
    .mult_stall(mult_stall), .stallreq_from_if(stallreq_from_if),
    .stallreq_from_mem(stallreq_from_mem), .mem_excepttype(mem_excepttype),
    .mem_cp0_epc(mem_cp0_epc), .stall(stall1), .flush(flush1), .div_start(start1),
    .div_cancel(cancel1), .div_timeout(tmo1), .newpc(newpc1), .newpc_valid(nv1),
    .exc_pending(pend1), .perf_lu(plu1), .perf_div(pdiv1), .perf_mem(pmem1)
  );

  pipe_hazard_ctrl #(.LOAD_LAT(2), .DIV_TIMEOUT(8)) u_dut2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt), .mem_rt(mem_rt),
    .ex_rmem(ex_rmem), .mem_rmem(mem_rmem), .ex_is_div(ex_is_div), .div_ready(div_ready),
    .mult_stall(mult_stall), .stallreq_from_if(stallreq_from_if),
    .stallreq_from_mem(stallreq_from_mem), .mem_excepttype(mem_excepttype),
    .mem_cp0_epc(mem_cp0_epc), .stall(stall2), .flush(flush2), .div_start(start2),
    .div_cancel(cancel2), .div_timeout(tmo2), .newpc(newpc2), .newpc_valid(nv2),
    .exc_pending(pend2), .perf_lu(plu2), .perf_div(pdiv2), .perf_mem(pmem2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    id_rs = '0; id_rt = '0; ex_rt = '0; mem_rt = '0;
    ex_rmem = 1'b0; mem_rmem = 1'b0; ex_is_div = 1'b0; div_ready = 1'b0;
    mult_stall = 1'b0; stallreq_from_if = 1'b0; stallreq_from_mem = 1'b0;
    mem_excepttype = '0; mem_cp0_epc = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    int starts, stalls, to_cnt, to_cyc;
    logic [4:0] st_c9;
    logic       sd_c9;

    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_stall", 32'(stall1), 32'h0);
    chk("rst_flush", 32'(flush1), 32'h0);
    chk("rst_pend", 32'(pend1), 32'h0);
    chk("rst_nv", 32'(nv1), 32'h0);
    chk("rst_start", 32'(start1), 32'h0);
    chk("rst_perf", plu1 | pdiv1 | pmem1, 32'h0);

    // load-use through EX
    tick();
    ex_rmem = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    chk("lu_ex_stall", 32'(stall1), 32'h03);
    chk("lu_ex_flush", 32'(flush1), 32'h04);
    ex_rt = 5'd0; id_rs = 5'd0;
    #1;
    chk("lu_r0_stall", 32'(stall1), 32'h0);
    chk("lu_r0_flush", 32'(flush1), 32'h0);
    ex_rt = 5'd12; id_rt = 5'd12;
    #1;
    chk("lu_ex_rt_stall", 32'(stall1), 32'h03);

    // load-use through MEM only matters for LOAD_LAT=2
    tick();
    clear_inputs();
    mem_rmem = 1'b1; mem_rt = 5'd9; id_rt = 5'd9;
    #1;
    chk("lu_mem2_stall", 32'(stall2), 32'h03);
    chk("lu_mem2_flush", 32'(flush2), 32'h04);
    chk("lu_mem1_stall", 32'(stall1), 32'h0);

    // single-source and multi-source stall patterns
    tick();
    clear_inputs();
    stallreq_from_if = 1'b1;
    #1;
    chk("if_stall", 32'(stall1), 32'h01);
    chk("if_flush", 32'(flush1), 32'h02);
    mult_stall = 1'b1;
    #1;
    chk("mult_stall", 32'(stall1), 32'h07);
    chk("mult_flush", 32'(flush1), 32'h08);
    stallreq_from_mem = 1'b1;
    #1;
    chk("mem_stall", 32'(stall1), 32'h0F);
    chk("mem_flush", 32'(flush1), 32'h10);

    // divide with result after 10 busy cycles
    do_reset();
    ex_is_div = 1'b1;
    starts = 0; stalls = 0;
    for (int c = 0; c < 11; c++) begin
      div_ready = (c == 10);
      #1;
      if (start1) starts++;
      if (stall1 == 5'b00111) stalls++;
      tick();
    end
    div_ready = 1'b0;
    #1;
    chk("div_done_stall", 32'(stall1), 32'h0);
    chk("div_done_start", 32'(start1), 32'h0);
    chk("div_starts", 32'(starts), 32'd1);
    chk("div_stall_cycles", 32'(stalls), 32'd11);

    // watchdog on the DIV_TIMEOUT=8 instance
    do_reset();
    ex_is_div = 1'b1;
    to_cnt = 0; to_cyc = -1; st_c9 = '1; sd_c9 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 9) ex_is_div = 1'b0;
      #1;
      if (tmo2) begin
        to_cnt++;
        to_cyc = c;
      end
      if (c == 9) begin
        st_c9 = stall2;
        sd_c9 = start2;
      end
      tick();
    end
    chk("wd_pulses", 32'(to_cnt), 32'd1);
    chk("wd_cycle", 32'(to_cyc), 32'd8);
    chk("wd_idle_stall", 32'(st_c9), 32'h0);
    chk("wd_idle_start", 32'(sd_c9), 32'h0);

    // exception deferred behind a memory stall
    do_reset();
    stallreq_from_mem = 1'b1; mem_excepttype = 32'd8; mem_cp0_epc = 32'h11112222;
    #1;
    chk("defer_stall", 32'(stall1), 32'h0F);
    chk("defer_flush", 32'(flush1), 32'h10);
    chk("defer_nv", 32'(nv1), 32'h0);
    tick();
    mem_excepttype = 32'h0000000E;
    #1;
    chk("defer_pend1", 32'(pend1), 32'h1);
    tick();
    #1;
    chk("defer_pend2", 32'(pend1), 32'h1);
    tick();
    stallreq_from_mem = 1'b0; mem_excepttype = '0;
    #1;
    chk("release_flush", 32'(flush1), 32'h1F);
    chk("release_stall", 32'(stall1), 32'h0);
    chk("release_newpc", newpc1, 32'hBFC00380);
    chk("release_nv", 32'(nv1), 32'h1);
    tick();
    #1;
    chk("release_pend_clr", 32'(pend1), 32'h0);
    chk("release_nv_clr", 32'(nv1), 32'h0);

    // immediate ERET overrides an active load-use stall
    mem_excepttype = 32'h0000000E; mem_cp0_epc = 32'h80001234;
    ex_rmem = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
    #1;
    chk("eret_newpc", newpc1, 32'h80001234);
    chk("eret_flush", 32'(flush1), 32'h1F);
    chk("eret_stall", 32'(stall1), 32'h0);
    chk("eret_nv", 32'(nv1), 32'h1);
    mem_excepttype = 32'h00000055;
    #1;
    chk("unk_newpc", newpc1, 32'hBFC00380);

    // reset while an exception is pending
    tick();
    clear_inputs();
    stallreq_from_mem = 1'b1; mem_excepttype = 32'd4;
    tick();
    #1;
    chk("rstpend_set", 32'(pend1), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    chk("rstpend_clr", 32'(pend1), 32'h0);
    chk("rstpend_nv", 32'(nv1), 32'h0);

    // exception while the divider is busy
    do_reset();
    ex_is_div = 1'b1;
    tick(); tick();
    #1;
    chk("cancel_busy_stall", 32'(stall1), 32'h07);
    tick();
    mem_excepttype = 32'd8;
    #1;
    chk("cancel_pulse", 32'(cancel1), 32'h1);
    chk("cancel_flush", 32'(flush1), 32'h1F);
    chk("cancel_stall", 32'(stall1), 32'h0);
    chk("cancel_no_start", 32'(start1), 32'h0);
    tick();
    mem_excepttype = '0; ex_is_div = 1'b0;
    #1;
    chk("cancel_idle_stall", 32'(stall1), 32'h0);
    chk("cancel_once", 32'(cancel1), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
